// File: rtl/div_share_if.sv
// Request/response bundle for div_share_ctrl: two operand requesters and one result consumer.
interface div_share_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_dividend;
  logic [WIDTH-1:0] req0_divisor;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_dividend;
  logic [WIDTH-1:0] req1_divisor;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_err;

  modport master (
    output req0_valid, req0_dividend, req0_divisor,
    output req1_valid, req1_dividend, req1_divisor,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, quotient, remainder, div_err
  );

  modport slave (
    input  req0_valid, req0_dividend, req0_divisor,
    input  req1_valid, req1_dividend, req1_divisor,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, quotient, remainder, div_err
  );
endinterface

// File: rtl/div_share_ctrl.sv
// Round-robin shared iterative restoring divider (one quotient bit per clock, WIDTH >= 2).
// Optional divide-by-zero short-cut and flag: define DIV_ZERO_DETECT_EN.
module div_share_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  div_share_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic             ptr;
  logic [WIDTH-1:0] q_sr, dvsr, rem;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo_r, rem_r;
  logic             id_r;
  logic             gnt0, gnt1, hs, last_iter, zero_div, qbit;
  logic [WIDTH-1:0] sel_dividend, sel_divisor, trial, rem_nxt, q_nxt;
  logic [WIDTH:0]   shifted;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      gnt0 = bus.req0_valid & (~bus.req1_valid | ~ptr);
      gnt1 = bus.req1_valid & (~bus.req0_valid | ptr);
    end
  end

  assign hs           = gnt0 | gnt1;
  assign sel_dividend = gnt1 ? bus.req1_dividend : bus.req0_dividend;
  assign sel_divisor  = gnt1 ? bus.req1_divisor  : bus.req0_divisor;

  // The restoring remainder never reaches the divisor, so it is kept WIDTH wide;
  // only the shifted value needs the extra bit, and a successful trial fits in WIDTH bits.
  assign shifted   = {rem, q_sr[WIDTH-1]};
  assign qbit      = shifted >= {1'b0, dvsr};
  assign trial     = shifted[WIDTH-1:0] - dvsr;
  assign rem_nxt   = qbit ? trial : shifted[WIDTH-1:0];
  assign q_nxt     = {q_sr[WIDTH-2:0], qbit};
  assign last_iter = (cnt == CW'(WIDTH - 1));

`ifdef DIV_ZERO_DETECT_EN
  assign zero_div = (sel_divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = zero_div ? DONE : CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= 1'b0;
      q_sr  <= '0;
      dvsr  <= '0;
      rem   <= '0;
      cnt   <= '0;
      quo_r <= '0;
      rem_r <= '0;
      id_r  <= 1'b0;
    end else if (hs) begin
      q_sr <= sel_dividend;
      dvsr <= sel_divisor;
      rem  <= '0;
      cnt  <= '0;
      id_r <= gnt1;
      ptr  <= gnt0;
      if (zero_div) begin
        quo_r <= '1;
        rem_r <= sel_dividend;
      end
    end else if (state == CALC) begin
      q_sr <= q_nxt;
      rem  <= rem_nxt;
      cnt  <= cnt + 1'b1;
      if (last_iter) begin
        quo_r <= q_nxt;
        rem_r <= rem_nxt;
      end
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic err_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  err_r <= 1'b0;
    else if (hs && zero_div)                  err_r <= 1'b1;
    else if (state == CALC && last_iter)      err_r <= 1'b0;
    else if (state == DONE && bus.resp_ready) err_r <= 1'b0;
  end

  assign bus.div_err = err_r;
`else
  assign bus.div_err = 1'b0;
`endif

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_id    = id_r;
  assign bus.quotient   = quo_r;
  assign bus.remainder  = rem_r;
endmodule
